// File: rtl/stack_op_sequencer_if.sv
// Handshake and Stack-side signal bundle for stack_op_sequencer.
// The slave modport is the sequencer; the master modport is its environment (instruction source, consumer, Stack).
interface stack_op_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] stk_wr_data;
    logic             stk_wr_en;
    logic             stk_re_en_a;
    logic             stk_re_en_b;
    logic [WIDTH-1:0] stk_data_a;
    logic [WIDTH-1:0] stk_data_b;

    modport master (
        output instr, instr_valid, out_ready, stk_data_a, stk_data_b,
        input  instr_ready, out_data, out_valid, stk_wr_data, stk_wr_en, stk_re_en_a, stk_re_en_b
    );

    modport slave (
        input  instr, instr_valid, out_ready, stk_data_a, stk_data_b,
        output instr_ready, out_data, out_valid, stk_wr_data, stk_wr_en, stk_re_en_a, stk_re_en_b
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Instruction front-end driving a DEPTH-entry operand Stack, with a shadow depth count for trapping.
// Define STACK_SEQ_MUL_EN to make opcode 0x15 (MUL) legal; otherwise it traps as undefined.
module stack_op_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    stack_op_sequencer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    localparam logic [WIDTH-1:0] OP_PUSH = WIDTH'(8'h01);
    localparam logic [WIDTH-1:0] OP_POP  = WIDTH'(8'h02);
    localparam logic [WIDTH-1:0] OP_DUP  = WIDTH'(8'h03);
    localparam logic [WIDTH-1:0] OP_ADD  = WIDTH'(8'h10);
    localparam logic [WIDTH-1:0] OP_SUB  = WIDTH'(8'h11);
    localparam logic [WIDTH-1:0] OP_AND  = WIDTH'(8'h12);
    localparam logic [WIDTH-1:0] OP_OR   = WIDTH'(8'h13);
    localparam logic [WIDTH-1:0] OP_XOR  = WIDTH'(8'h14);
`ifdef STACK_SEQ_MUL_EN
    localparam logic [WIDTH-1:0] OP_MUL  = WIDTH'(8'h15);
`endif
    localparam logic [WIDTH-1:0] OP_OUT  = WIDTH'(8'h20);

    typedef enum logic [1:0] {
        S_FETCH,
        S_IMM,
        S_OUT_WAIT,
        S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_load;
    logic             ready_c;
    logic             accept_c;
    logic             is_binop_c;
    logic [WIDTH-1:0] alu_c;

    // Two-operand result with a (second entry) as the left operand
    always_comb begin
        alu_c      = '0;
        is_binop_c = 1'b1;
        case (bus.instr)
            OP_ADD:  alu_c = bus.stk_data_a + bus.stk_data_b;
            OP_SUB:  alu_c = bus.stk_data_a - bus.stk_data_b;
            OP_AND:  alu_c = bus.stk_data_a & bus.stk_data_b;
            OP_OR:   alu_c = bus.stk_data_a | bus.stk_data_b;
            OP_XOR:  alu_c = bus.stk_data_a ^ bus.stk_data_b;
`ifdef STACK_SEQ_MUL_EN
            OP_MUL:  alu_c = bus.stk_data_a * bus.stk_data_b;
`endif
            default: is_binop_c = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q    <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_q | (state_d == S_TRAP);
            if (out_load) begin
                out_data_q <= bus.stk_data_b;
            end
        end
    end

    // Next state, shadow depth and Stack strobes; strobes only fire on an accepted byte
    always_comb begin
        state_d         = state_q;
        depth_d         = depth_q;
        out_load        = 1'b0;
        ready_c         = 1'b0;
        bus.stk_wr_en   = 1'b0;
        bus.stk_re_en_a = 1'b0;
        bus.stk_re_en_b = 1'b0;
        bus.stk_wr_data = '0;

        if ((state_q == S_FETCH) || (state_q == S_IMM)) begin
            ready_c = !reset;
        end
        accept_c = bus.instr_valid && ready_c;

        case (state_q)
            S_FETCH: begin
                if (accept_c) begin
                    if (bus.instr == OP_PUSH) begin
                        state_d = (depth_q < DW'(DEPTH)) ? S_IMM : S_TRAP;
                    end else if (bus.instr == OP_POP) begin
                        if (depth_q >= DW'(1)) begin
                            bus.stk_re_en_b = 1'b1;
                            depth_d         = depth_q - DW'(1);
                        end else begin
                            state_d = S_TRAP;
                        end
                    end else if (bus.instr == OP_DUP) begin
                        if ((depth_q >= DW'(1)) && (depth_q < DW'(DEPTH))) begin
                            bus.stk_wr_en   = 1'b1;
                            bus.stk_wr_data = bus.stk_data_b;
                            depth_d         = depth_q + DW'(1);
                        end else begin
                            state_d = S_TRAP;
                        end
                    end else if (is_binop_c) begin
                        if (depth_q >= DW'(2)) begin
                            bus.stk_re_en_a = 1'b1;
                            bus.stk_re_en_b = 1'b1;
                            bus.stk_wr_en   = 1'b1;
                            bus.stk_wr_data = alu_c;
                            depth_d         = depth_q - DW'(1);
                        end else begin
                            state_d = S_TRAP;
                        end
                    end else if (bus.instr == OP_OUT) begin
                        if (depth_q >= DW'(1)) begin
                            bus.stk_re_en_b = 1'b1;
                            depth_d         = depth_q - DW'(1);
                            out_load        = 1'b1;
                            state_d         = S_OUT_WAIT;
                        end else begin
                            state_d = S_TRAP;
                        end
                    end else begin
                        state_d = S_TRAP;
                    end
                end
            end
            S_IMM: begin
                // Room was checked when PUSH was decoded
                if (accept_c) begin
                    bus.stk_wr_en   = 1'b1;
                    bus.stk_wr_data = bus.instr;
                    depth_d         = depth_q + DW'(1);
                    state_d         = S_FETCH;
                end
            end
            S_OUT_WAIT: begin
                if (bus.out_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    assign bus.instr_ready = ready_c;
    assign bus.out_valid   = (state_q == S_OUT_WAIT);
    assign bus.out_data    = out_data_q;
    assign depth           = depth_q;
    assign err             = err_q;
endmodule
